// File: rtl/demux1to4_32_buf_pkg.sv
// Shared lane constants and types for the buffered 1-to-4 word distributor.
package demux1to4_32_buf_pkg;

    localparam int NUM_LANES   = 4;
    localparam int LANE_W      = 2;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_CNTW    = 2;

    typedef logic [LANE_W-1:0] lane_sel_t;

    // A lane takes the incoming word when it is addressed directly or broadcast is requested.
    function automatic logic lane_hit(input lane_sel_t sel, input logic bcast,
                                      input int unsigned lane);
        return bcast | (sel == lane_sel_t'(lane));
    endfunction

endpackage

// File: rtl/demux1to4_32_buf_if.sv
// Producer-side input bus plus the four consumer lanes of the distributor.
interface demux1to4_32_buf_if
    import demux1to4_32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
);
    logic                       in_valid;
    logic                       in_ready;
    lane_sel_t                  in_sel;
    logic                       in_bcast;
    logic [WIDTH-1:0]           in_data;
    logic [NUM_LANES-1:0]       out_valid;
    logic [NUM_LANES-1:0]       out_ready;
    logic [WIDTH-1:0]           out_d0;
    logic [WIDTH-1:0]           out_d1;
    logic [WIDTH-1:0]           out_d2;
    logic [WIDTH-1:0]           out_d3;
    logic [NUM_LANES*CNTW-1:0]  lane_cnt;

    modport master (
        output in_valid, in_sel, in_bcast, in_data, out_ready,
        input  in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, lane_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_bcast, in_data, out_ready,
        output in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, lane_cnt
    );

endinterface

// File: rtl/demux1to4_32_buf_lane_fifo_32.sv
// One lane FIFO: power-of-two depth, registered count, head forced to zero when empty.
module lane_fifo_32 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head,
    output logic [CNTW-1:0]  o_count
);
    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & o_valid;
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is cleared on reset so no stale word can ever reach a head output;
            // this is deliberate for a tiny buffer and would be dropped for a RAM-backed FIFO.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux1to4_32_buf.sv
// Buffered 1-to-4 distributor: routes or broadcasts each accepted word into per-lane FIFOs.
module demux1to4_32_buf
    import demux1to4_32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1to4_32_buf_if.slave  bus
);
    logic [NUM_LANES-1:0]            w_full;
    logic [NUM_LANES-1:0]            w_valid;
    logic [NUM_LANES-1:0]            w_push;
    logic [WIDTH-1:0]                w_head [NUM_LANES];
    logic [NUM_LANES-1:0][CNTW-1:0]  w_count;

    // Acceptance looks only at registered fullness; a pop this cycle never frees a slot early.
    assign bus.in_ready = bus.in_bcast ? ~|w_full : ~w_full[bus.in_sel];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_push[g] = bus.in_valid & bus.in_ready
                         & lane_hit(bus.in_sel, bus.in_bcast, g);

        lane_fifo_32 #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_push      (w_push[g]),
            .i_push_data (bus.in_data),
            .i_pop       (bus.out_ready[g]),
            .o_full      (w_full[g]),
            .o_valid     (w_valid[g]),
            .o_head      (w_head[g]),
            .o_count     (w_count[g])
        );
    end

    assign bus.out_valid = w_valid;
    assign bus.lane_cnt  = w_count;
    assign bus.out_d0    = w_head[0];
    assign bus.out_d1    = w_head[1];
    assign bus.out_d2    = w_head[2];
    assign bus.out_d3    = w_head[3];

endmodule

// File: tb/tb_demux1to4_32_buf.sv
// Directed bench with a per-lane scoreboard queue for the buffered 1-to-4 distributor.
module tb_demux1to4_32_buf;
    import demux1to4_32_buf_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNTW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [WIDTH-1:0] sb_q [NUM_LANES][$];

    demux1to4_32_buf_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    demux1to4_32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] head(input int i);
        case (i)
            0:       return bus.out_d0;
            1:       return bus.out_d1;
            2:       return bus.out_d2;
            default: return bus.out_d3;
        endcase
    endfunction

    task automatic check_state();
        logic [WIDTH-1:0] exp_head;
        for (int i = 0; i < NUM_LANES; i++) begin
            exp_head = (sb_q[i].size() != 0) ? sb_q[i][0] : '0;
            check($sformatf("lane%0d_valid", i), 32'(bus.out_valid[i]), 32'(sb_q[i].size() != 0));
            check($sformatf("lane%0d_cnt", i), 32'(bus.lane_cnt[i*CNTW +: CNTW]),
                  32'(sb_q[i].size()));
            check($sformatf("lane%0d_head", i), head(i), exp_head);
        end
    endtask

    // One clock: drive inputs, check in_ready and popped words, then check state after the edge.
    task automatic step(input logic v, input logic [1:0] sel, input logic bc,
                        input logic [31:0] d, input logic [3:0] ordy);
        logic             exp_rdy;
        logic [WIDTH-1:0] popped;
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_bcast  = bc;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #2;
        exp_rdy = 1'b1;
        if (bc) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (sb_q[i].size() == DEPTH) exp_rdy = 1'b0;
        end else begin
            exp_rdy = (sb_q[sel].size() < DEPTH);
        end
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        for (int i = 0; i < NUM_LANES; i++) begin
            if (ordy[i] && sb_q[i].size() != 0) begin
                popped = sb_q[i].pop_front();
                check($sformatf("pop_data%0d", i), head(i), popped);
            end
        end
        if (v && exp_rdy) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (bc || sel == 2'(i)) sb_q[i].push_back(d);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        check_state();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_bcast  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;

        // Reset held low
        #3;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check_state();
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routed push, then idle inputs wiggling with in_valid=0
        step(1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 4'b0000);
        step(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 4'b0000);
        step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0100);

        // Fill lane 1, backpressure, then drain in order
        step(1'b1, 2'd1, 1'b0, 32'h1111_1111, 4'b0000);
        step(1'b1, 2'd1, 1'b0, 32'h2222_2222, 4'b0000);
        step(1'b1, 2'd1, 1'b0, 32'h3333_3333, 4'b0000);
        step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
        step(1'b1, 2'd1, 1'b0, 32'h4444_4444, 4'b0010);
        step(1'b0, 2'd1, 1'b0, 32'h0, 4'b0010);
        step(1'b0, 2'd1, 1'b0, 32'h0, 4'b1111);

        // Broadcast, drain, then broadcast blocked by a full lane 3
        step(1'b1, 2'd0, 1'b1, 32'hA5A5_A5A5, 4'b0000);
        step(1'b0, 2'd0, 1'b0, 32'h0, 4'b1111);
        step(1'b1, 2'd3, 1'b0, 32'h3000_0001, 4'b0000);
        step(1'b1, 2'd3, 1'b0, 32'h3000_0002, 4'b0000);
        step(1'b1, 2'd0, 1'b1, 32'h5A5A_5A5A, 4'b0000);
        step(1'b0, 2'd3, 1'b0, 32'h0, 4'b1000);
        step(1'b0, 2'd3, 1'b0, 32'h0, 4'b1000);

        // Same-lane push+pop at count 1, repeated across pointer wraps
        step(1'b1, 2'd0, 1'b0, 32'h0000_0001, 4'b0000);
        for (int k = 0; k < 8; k++)
            step(1'b1, 2'd0, 1'b0, 32'(k + 2), 4'b0001);
        // Push+pop at count DEPTH is refused on the push side
        step(1'b1, 2'd0, 1'b0, 32'h0000_00AA, 4'b0000);
        step(1'b1, 2'd0, 1'b0, 32'h0000_00BB, 4'b0001);
        step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0001);
        step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0001);

        // Partly fill lanes, then async reset mid-cycle
        step(1'b1, 2'd0, 1'b0, 32'hC0C0_0000, 4'b0000);
        step(1'b1, 2'd1, 1'b0, 32'hC1C1_0001, 4'b0000);
        step(1'b1, 2'd1, 1'b0, 32'hC1C1_0002, 4'b0000);
        step(1'b1, 2'd2, 1'b0, 32'hC2C2_0000, 4'b0000);
        #2 rst_n = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) sb_q[i].delete();
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check_state();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();
        step(1'b1, 2'd3, 1'b0, 32'hCAFE_F00D, 4'b0000);
        step(1'b1, 2'd1, 1'b0, 32'h1234_5678, 4'b1000);
        step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
